// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared fetch FSM states and constants
package fetch_pkg;
    typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} fetch_state_t;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: redirect, imem and decode handshake bundle
interface fetch_sequencer_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready;
    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst_pc, inst_data
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst_pc, inst_data
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: one-outstanding-request fetch FSM with redirect squash
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  bus,
    output logic [31:0]        pc,
    output logic               misaligned
);
    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         inst_valid_q, inst_valid_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic [31:0]  inst_data_q, inst_data_d;
    logic         misaligned_q, misaligned_d;

    // Next state: stream events first, then a redirect overrides pc/misaligned
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        inst_pc_d    = inst_pc_q;
        inst_data_d  = inst_data_q;
        misaligned_d = misaligned_q;
        case (state_q)
            REQ:   state_d = bus.imem_gnt ? (bus.redirect_valid ? DRAIN : WAIT) : REQ;
            WAIT: begin
                if (bus.imem_rvalid && !bus.redirect_valid) begin
                    inst_data_d  = bus.imem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + 32'(INSTR_BYTES);
                    state_d      = HOLD;
                end else if (bus.imem_rvalid) begin
                    state_d = REQ;
                end else if (bus.redirect_valid) begin
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (bus.inst_ready || bus.redirect_valid) begin
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end
            end
            DRAIN: state_d = bus.imem_rvalid ? REQ : DRAIN;
            default: state_d = REQ;
        endcase
        if (bus.redirect_valid) begin
            pc_d         = {bus.redirect_pc[31:2], 2'b00};
            misaligned_d = |bus.redirect_pc[1:0];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REQ;
            pc_q         <= RESET_VECTOR;
            inst_valid_q <= 1'b0;
            inst_pc_q    <= '0;
            inst_data_q  <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_pc_q    <= inst_pc_d;
            inst_data_q  <= inst_data_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.imem_req   = (state_q == REQ) && !rst;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_data  = inst_data_q;
    assign pc             = pc_q;
    assign misaligned     = misaligned_q;

    // A response may only arrive while a request is outstanding
    assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_rvalid && (state_q == REQ || state_q == HOLD)));
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle instruction-fetch controller that owns the architectural fetch PC and sequences one instruction-memory request at a time.
- Delivers each fetched instruction, tagged with its PC, to decode through a valid/ready handshake.
- Accepts redirects (branch, jump or trap targets) at any point. Fetches already in flight for a redirected stream are discarded.
- Sits between the PC/next-PC logic of the core and the instruction memory port.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- redirect_valid  input  1  load redirect_pc as the new fetch PC this cycle.
- redirect_pc  input  32  redirect target.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals pc.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response data valid (one per granted request, at least 1 cycle after gnt).
- imem_rdata  input  32  instruction word.
- inst_valid  output  1  instruction available to decode.
- inst_pc  output  32  PC of the delivered instruction.
- inst_data  output  32  delivered instruction word.
- inst_ready  input  1  decode accepts the instruction.
- pc  output  32  current fetch PC.
- misaligned  output  1  last accepted redirect had redirect_pc[1:0] != 0 (sticky).

Behaviour:
- Reset (rst=1 at edge):
  - state=REQ, pc=RESET_VECTOR.
  - inst_valid=0, inst_pc=0, inst_data=0, misaligned=0.
  - imem_req is 0 while rst is high.
- States: REQ, WAIT, HOLD, DRAIN. imem_req=1 only in REQ (and rst=0). At most one request is outstanding.
- Redirect load:
  - pc <= {redirect_pc[31:2],2'b00}.
  - misaligned <= |redirect_pc[1:0].
  - A redirect always has priority over every other event in the same cycle.
- REQ:
  - gnt and no redirect -> WAIT.
  - gnt with redirect -> load redirect, go to DRAIN (the granted fetch is stale).
  - No gnt with redirect -> load redirect, stay in REQ. imem_addr may change while gnt is low.
- WAIT:
  - rvalid and no redirect -> inst_data<=rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4, go to HOLD.
  - rvalid with redirect -> discard data, load redirect, go to REQ.
  - No rvalid with redirect -> load redirect, go to DRAIN.
- HOLD (inst_valid=1, outputs stable):
  - inst_ready and no redirect -> inst_valid<=0, go to REQ.
  - Redirect (with or without inst_ready) -> inst_valid<=0, load redirect, go to REQ. The held instruction is squashed, not consumed.
- DRAIN:
  - Wait for rvalid, discard data, go to REQ.
  - Redirect in DRAIN -> load redirect, stay in DRAIN; on a simultaneous rvalid, go to REQ.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Throughput: minimum 3 cycles per instruction (REQ, WAIT, HOLD) with zero-wait memory and inst_ready=1.
- Reset mid-operation: any state returns to REQ with reset values. A response arriving after reset for a pre-reset request is not tracked; the memory is reset together with the core.
- rvalid in REQ or HOLD is a protocol violation: it is ignored and covered by an assertion.
- Latency: inst_valid rises the cycle after the rvalid edge in WAIT.

Decomposition:
- Shared package fetch_pkg holds:
  - typedef enum logic [1:0] fetch_state_t {REQ, WAIT, HOLD, DRAIN}.
  - localparam INSTR_BYTES = 4.
  - Default reset-vector constant, reused by the pipelined fetch stage.
- No sub-module is required. The PC register and next-PC selection stay inline because reset here is synchronous.

Test Plan:
- Reset release, memory with gnt same cycle and rvalid 1 cycle later, inst_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; inst_pc/inst_data match with 3-cycle spacing.
- inst_ready held low 5 cycles in HOLD -> inst_valid, inst_pc, inst_data stable; no imem_req until ready; then next addr = inst_pc+4.
- Redirect to 0x100 in WAIT without rvalid -> DRAIN; old response discarded (inst_valid stays 0); next imem_addr=0x100.
- Redirect to 0x200 in HOLD with inst_ready=1 simultaneously -> inst_valid drops, no delivery; next imem_addr=0x200.
- Redirect to 0x103 -> imem_addr=0x100, misaligned=1; later redirect to 0x80 -> misaligned=0.
- pc=0xFFFF_FFFC fetch completes -> next imem_addr=0x0000_0000. Assert rst in WAIT -> next cycle state REQ, pc=RESET_VECTOR, inst_valid=0.
